// File: rtl/rst_seq_pkg.sv
// Shared state encoding and width helper for the reset sequencer.
package rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_POR       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_if.sv
// Inputs and status outputs of the reset sequencer, grouped as one bundle.
interface rst_seq_ctrl_if #(
  parameter int NUM_DOM = 4
);
  import rst_seq_pkg::*;

  logic                 pll_lock_i;
  logic                 soft_rst_i;
  logic [NUM_DOM-1:0]   dom_rstn_o;
  logic                 por_done_o;
  logic                 lock_lost_o;
  logic [STATE_W-1:0]   state_o;
  logic                 heartbeat_o;

  modport master (
    output pll_lock_i, soft_rst_i,
    input  dom_rstn_o, por_done_o, lock_lost_o, state_o, heartbeat_o
  );

  modport slave (
    input  pll_lock_i, soft_rst_i,
    output dom_rstn_o, por_done_o, lock_lost_o, state_o, heartbeat_o
  );
endinterface

// File: rtl/rst_seq_ctrl_sync_debounce.sv
// Two-flop synchroniser with optional debounce; DEBOUNCE=1 gives the bare synchroniser.
module sync_debounce
  import rst_seq_pkg::*;
#(
  parameter int DEBOUNCE = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic level_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  generate
    if (DEBOUNCE <= 1) begin : g_sync_only
      assign level_o = sync_q;
    end else begin : g_debounce
      localparam int DB_W = clog2(DEBOUNCE);
      logic [DB_W-1:0] cnt_q, cnt_d;
      logic            level_q, level_d;

      // Counter only runs while the input disagrees with the held level.
      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync_q != level_q) begin
          if (cnt_q == DB_W'(DEBOUNCE - 1)) level_d = sync_q;
          else                              cnt_d   = cnt_q + DB_W'(1);
        end
      end

      always_ff @(posedge clock) begin
        if (!reset) begin
          cnt_q   <= '0;
          level_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          level_q <= level_d;
        end
      end

      assign level_o = level_q;
    end
  endgenerate

endmodule

// File: rtl/rst_seq_ctrl.sv
// Power-on / PLL-lock qualified reset sequencer with staggered domain release.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM     = 4,
  parameter int POR_CYCLES  = 40000000,
  parameter int LOCK_STABLE = 256,
  parameter int STAGGER     = 16,
  parameter int DEBOUNCE    = 1024,
  parameter int HOLD_CYCLES = 64,
  parameter int HB_BIT      = 21,
  parameter int CNT_W       = 32
) (
  input logic           clock,
  input logic           reset,
  rst_seq_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_DOM > 1) ? clog2(NUM_DOM) : 1;
  localparam int HB_W  = HB_BIT + 1;

  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

  logic lock_sync, soft_lvl, soft_lvl_q, soft_req;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               por_done_q, por_done_d;
  logic               lock_lost_q, lock_lost_d;
  logic [HB_W-1:0]    hb_q;

  sync_debounce #(.DEBOUNCE(1)) u_lock_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (bus.pll_lock_i),
    .level_o (lock_sync)
  );

  sync_debounce #(.DEBOUNCE(DEBOUNCE)) u_soft_db (
    .clock   (clock),
    .reset   (reset),
    .async_i (bus.soft_rst_i),
    .level_o (soft_lvl)
  );

  assign soft_req = soft_lvl & ~soft_lvl_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_POR;
      cnt_q       <= '0;
      idx_q       <= '0;
      dom_q       <= '0;
      por_done_q  <= 1'b0;
      lock_lost_q <= 1'b0;
      soft_lvl_q  <= 1'b0;
      hb_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dom_q       <= dom_d;
      por_done_q  <= por_done_d;
      lock_lost_q <= lock_lost_d;
      soft_lvl_q  <= soft_lvl;
      hb_q        <= hb_q + HB_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      ST_POR: begin
        if (cnt_q == POR_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (!lock_sync) begin
          cnt_d = '0;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE, ST_RUN: begin
        // Re-entry wins over any release progress in the same cycle.
        if (soft_req || !lock_sync) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (state_q == ST_RELEASE) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else if (cnt_q == STAG_LAST) begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (soft_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_POR;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    dom_d = '0;
    case (state_d)
      ST_RUN: dom_d = '1;
      ST_RELEASE: begin
        for (int i = 0; i < NUM_DOM; i++) dom_d[i] = (IDX_W'(i) <= idx_d);
      end
      default: dom_d = '0;
    endcase
    por_done_d  = por_done_q | (state_d != ST_POR);
    lock_lost_d = lock_lost_q |
                  (((state_q == ST_RELEASE) || (state_q == ST_RUN)) && !lock_sync);
  end

  assign bus.dom_rstn_o  = dom_q;
  assign bus.por_done_o  = por_done_q;
  assign bus.lock_lost_o = lock_lost_q;
  assign bus.state_o     = state_q;
  assign bus.heartbeat_o = hb_q[HB_BIT];

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with shortened timing parameters.
module tb_rst_seq_ctrl;
  import rst_seq_pkg::*;

  localparam int NUM_DOM = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rst_seq_ctrl_if #(.NUM_DOM(NUM_DOM)) bus ();

  rst_seq_ctrl #(
    .NUM_DOM     (NUM_DOM),
    .POR_CYCLES  (100),
    .LOCK_STABLE (8),
    .STAGGER     (4),
    .DEBOUNCE    (16),
    .HOLD_CYCLES (10),
    .HB_BIT      (3),
    .CNT_W       (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sd(input string tag, input logic [2:0] st, input logic [3:0] dom);
    chk({tag, "_state"}, 32'(bus.state_o), 32'(st));
    chk({tag, "_dom"}, 32'(bus.dom_rstn_o), 32'(dom));
  endtask

  task automatic chk_all_reset(input string tag);
    chk_sd(tag, 3'd0, 4'h0);
    chk({tag, "_por"}, 32'(bus.por_done_o), 32'd0);
    chk({tag, "_ll"}, 32'(bus.lock_lost_o), 32'd0);
    chk({tag, "_hb"}, 32'(bus.heartbeat_o), 32'd0);
  endtask

  // Edge k after reset deasserts: heartbeat = bit 3 of k, por_done at k=100.
  task automatic por_run(input string tag);
    for (int k = 1; k <= 100; k++) begin
      cyc(1);
      if (k == 7)  chk({tag, "_hb7"}, 32'(bus.heartbeat_o), 32'd0);
      if (k == 8)  chk({tag, "_hb8"}, 32'(bus.heartbeat_o), 32'd1);
      if (k == 16) chk({tag, "_hb16"}, 32'(bus.heartbeat_o), 32'd0);
      if (k == 99) begin
        chk({tag, "_por99"}, 32'(bus.por_done_o), 32'd0);
        chk({tag, "_st99"}, 32'(bus.state_o), 32'd0);
      end
      if (k == 100) begin
        chk({tag, "_por100"}, 32'(bus.por_done_o), 32'd1);
        chk({tag, "_st100"}, 32'(bus.state_o), 32'd1);
      end
    end
  endtask

  initial begin
    bus.pll_lock_i = 1'b1;
    bus.soft_rst_i = 1'b0;
    cyc(3);
    chk_all_reset("rst0");
    reset = 1'b1;

    // Power-up with lock held high
    por_run("pu");
    cyc(7);  chk_sd("pu_e107", 3'd1, 4'h0);
    cyc(1);  chk_sd("pu_e108", 3'd2, 4'h1);
    cyc(3);  chk_sd("pu_e111", 3'd2, 4'h1);
    cyc(1);  chk_sd("pu_e112", 3'd2, 4'h3);
    cyc(4);  chk_sd("pu_e116", 3'd2, 4'h7);
    cyc(4);  chk_sd("pu_e120", 3'd2, 4'hF);
    cyc(1);  chk_sd("pu_run", 3'd3, 4'hF);

    // Short soft pulse is filtered
    bus.soft_rst_i = 1'b1;
    cyc(10);
    bus.soft_rst_i = 1'b0;
    cyc(30);
    chk_sd("soft10", 3'd3, 4'hF);

    // Long soft pulse: HOLD entry 19 edges after drive, 10 cycles of HOLD
    bus.soft_rst_i = 1'b1;
    cyc(18); chk_sd("soft20_s18", 3'd3, 4'hF);
    cyc(1);  chk_sd("soft20_hold", 3'd4, 4'h0);
    chk("soft20_por", 32'(bus.por_done_o), 32'd1);
    chk("soft20_ll", 32'(bus.lock_lost_o), 32'd0);
    cyc(1);
    bus.soft_rst_i = 1'b0;
    bus.pll_lock_i = 1'b0;
    cyc(8);  chk("hold_s28", 32'(bus.state_o), 32'd4);
    cyc(1);  chk("hold_s29", 32'(bus.state_o), 32'd1);
    chk("hold_ll", 32'(bus.lock_lost_o), 32'd0);

    // Lock runs shorter than 8 do not qualify
    bus.pll_lock_i = 1'b1; cyc(5);
    bus.pll_lock_i = 1'b0; cyc(2);
    bus.pll_lock_i = 1'b1; cyc(7);
    bus.pll_lock_i = 1'b0; cyc(1);
    bus.soft_rst_i = 1'b1; cyc(1);
    chk_sd("tog_t0", 3'd1, 4'h0);
    bus.pll_lock_i = 1'b1;
    cyc(9);  chk_sd("tog_t9", 3'd1, 4'h0);
    cyc(1);  chk_sd("tog_t10", 3'd2, 4'h1);
    cyc(4);  chk_sd("tog_t14", 3'd2, 4'h3);

    // Lock loss and soft request land on the same edge (T+18)
    cyc(1);  bus.pll_lock_i = 1'b0;
    cyc(1);  bus.pll_lock_i = 1'b1;
    cyc(1);  chk_sd("both_t17", 3'd2, 4'h3);
    chk("both_ll17", 32'(bus.lock_lost_o), 32'd0);
    cyc(1);  chk_sd("both_t18", 3'd4, 4'h0);
    chk("both_ll18", 32'(bus.lock_lost_o), 32'd1);
    chk("both_por", 32'(bus.por_done_o), 32'd1);
    cyc(1);  bus.soft_rst_i = 1'b0;
    cyc(8);  chk("both_hold27", 32'(bus.state_o), 32'd4);
    cyc(1);  chk("both_wait28", 32'(bus.state_o), 32'd1);
    cyc(8);  chk_sd("both_rel36", 3'd2, 4'h1);

    // Reset in the middle of RELEASE
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk_all_reset("midrst");
    reset = 1'b1;
    por_run("rr");
    cyc(21); chk_sd("rr_run", 3'd3, 4'hF);
    chk("rr_ll", 32'(bus.lock_lost_o), 32'd0);

    // One-clock lock drop in RUN
    bus.pll_lock_i = 1'b0;
    cyc(1);  bus.pll_lock_i = 1'b1;
    cyc(1);  chk_sd("ld_l2", 3'd3, 4'hF);
    chk("ld_ll2", 32'(bus.lock_lost_o), 32'd0);
    cyc(1);  chk_sd("ld_l3", 3'd4, 4'h0);
    chk("ld_ll3", 32'(bus.lock_lost_o), 32'd1);
    cyc(9);  chk("ld_l12", 32'(bus.state_o), 32'd4);
    cyc(1);  chk("ld_l13", 32'(bus.state_o), 32'd1);
    cyc(7);  chk_sd("ld_l20", 3'd1, 4'h0);
    cyc(1);  chk_sd("ld_l21", 3'd2, 4'h1);
    cyc(12); chk_sd("ld_l33", 3'd2, 4'hF);
    cyc(1);  chk_sd("ld_run", 3'd3, 4'hF);
    chk("ld_ll_sticky", 32'(bus.lock_lost_o), 32'd1);
    chk("ld_por", 32'(bus.por_done_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Parametrised reset sequencer that replaces the fixed single-counter power-on reset at the MCU top level. It counts a power-on delay, then qualifies PLL lock. It releases NUM_DOM reset domains in a fixed staggered order (domain 0 first). It re-enters reset on a debounced soft-reset request or on loss of PLL lock. It also supplies a heartbeat LED and status flags to the top level and CPU.

Parameters:
NUM_DOM, 4, number of reset domains (1..8)
POR_CYCLES, 40000000, clocks counted after reset before lock qualification
LOCK_STABLE, 256, consecutive clocks pll lock must be high before release
STAGGER, 16, clocks between successive domain releases
DEBOUNCE, 1024, clocks soft-reset input must be stable to register a change
HOLD_CYCLES, 64, minimum clocks all domains are held in reset after a re-entry
HB_BIT, 21, heartbeat counter bit driven to heartbeat_o
CNT_W, 32, width of shared delay counter; must satisfy 2^CNT_W > max(POR_CYCLES, HOLD_CYCLES, LOCK_STABLE, STAGGER)

Ports:
clock  in  1  single system clock
reset  in  1  synchronous, active-low reset
pll_lock_i  in  1  PLL lock, asynchronous to clock
soft_rst_i  in  1  soft-reset button, active high, asynchronous, bouncing
dom_rstn_o  out  NUM_DOM  per-domain active-low reset, registered
por_done_o  out  1  high once POR_CYCLES has elapsed; sticky until reset
lock_lost_o  out  1  sticky; set when lock drops while in RUN or RELEASE
state_o  out  3  current FSM state encoding
heartbeat_o  out  1  bit HB_BIT of free-running counter

Behaviour:
- Reset (reset=0 at a clock edge) drives the following values:
  - dom_rstn_o=0 on all domains; por_done_o=0; lock_lost_o=0; heartbeat_o=0.
  - All counters clear; state=POR.
- Input synchronisation:
  - pll_lock_i and soft_rst_i each pass through a 2-flop synchroniser.
  - soft_rst_i is then debounced: the output changes only after DEBOUNCE consecutive equal synchronised samples.
  - The FSM acts on the rising edge of the debounced signal (soft_req, a one-cycle pulse).
- States and encoding: POR=0, WAIT_LOCK=1, RELEASE=2, RUN=3, HOLD=4.
- POR:
  - Counter increments each clock.
  - When it reaches POR_CYCLES-1, the next cycle sets por_done_o=1 and moves to WAIT_LOCK.
  - soft_req and lock loss are ignored in this state.
- WAIT_LOCK:
  - Counter counts consecutive lock_sync=1 clocks and clears whenever lock_sync=0.
  - When it reaches LOCK_STABLE-1, move to RELEASE with domain index 0.
- RELEASE:
  - dom_rstn_o[0] goes high on the first cycle in RELEASE.
  - Each further domain i goes high exactly STAGGER clocks after domain i-1.
  - After domain NUM_DOM-1 is released, move to RUN on the next clock.
  - NUM_DOM=1: go from release directly to RUN.
- RUN: all dom_rstn_o=1.
- Re-entry from RELEASE or RUN:
  - Triggers: soft_req, or lock_sync=0 (lock loss also sets lock_lost_o=1).
  - On the next clock all dom_rstn_o=0 simultaneously and state=HOLD.
  - If both triggers occur in the same cycle: single entry to HOLD, lock_lost_o set.
- HOLD:
  - Count HOLD_CYCLES, then go to WAIT_LOCK.
  - POR is not rerun; por_done_o stays 1.
  - soft_req during HOLD restarts the HOLD count.
- Heartbeat counter:
  - Free-running, width HB_BIT+1, wraps silently.
  - Unaffected by FSM state; cleared only by reset.
- Reset mid-operation: an active reset at any state returns every output to its reset value on that edge.

Decomposition:
- Package rst_seq_pkg holds:
  - the state enum/localparams (POR..HOLD, 3-bit);
  - a clog2 helper for derived counter widths.
- The synchroniser plus debouncer is one natural sub-module, sync_debounce (parameter DEBOUNCE). It is instantiated for soft_rst_i; pll_lock_i uses only its 2-flop synchroniser path (DEBOUNCE=1).

Test Plan:
- Use POR_CYCLES=100, LOCK_STABLE=8, STAGGER=4, NUM_DOM=4, DEBOUNCE=16, HOLD_CYCLES=10 for all scenarios.
- Power-up with lock held high from t0 -> por_done_o rises exactly 100 clocks after reset deasserts. dom_rstn_o steps 0001, 0011, 0111, 1111 at 4-clock spacing. state_o reaches 3.
- Lock toggling in WAIT_LOCK with runs of high <8 clocks -> no domain released. A run of 8 consecutive high clocks -> domain 0 released.
- soft_rst_i pulse of 10 clocks (below DEBOUNCE) in RUN -> no change. A 20-clock pulse -> dom_rstn_o=0000, HOLD for 10 clocks, then lock qualification and staggered release again. por_done_o stays 1.
- pll_lock_i dropped for 1 clock in RUN -> lock_lost_o=1 (sticky), all domains reset. Re-release follows once lock is stable 8 clocks.
- Lock loss and debounced soft request in the same cycle during RELEASE (after 2 domains released) -> single HOLD entry, lock_lost_o=1, all outputs 0.
- reset asserted mid-RELEASE -> next edge gives all outputs 0 and state_o=0. After release of reset, the POR count restarts from 0.
